// File: rtl/dekoder_pkg.sv
// Shared types and constants for the flow-controlled one-hot decoder.
package dekoder_pkg;

   localparam int unsigned N    = 8;
   localparam int unsigned OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_PULSE  = 2'b00,
      OP_SET    = 2'b01,
      OP_CLEAR  = 2'b10,
      OP_TOGGLE = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

endpackage

// File: rtl/dekoder_onehot_dec.sv
// Purely combinational binary index to one-hot decode.
module onehot_dec #(
   parameter int unsigned n = 8
) (
   input  logic [n-1:0]        idx,
   output logic [(1<<n)-1:0]   onehot
);

   localparam int unsigned W = 1 << n;

   assign onehot = W'(1) << idx;

endmodule

// File: rtl/dekoder.sv
// Registered index-to-one-hot decoder with a 2-entry skid stage and a sticky
// bit mask updated whenever an entry lands in the head register.
module dekoder
   import dekoder_pkg::*;
#(
   parameter int unsigned n = N
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [n-1:0]        in_idx,
   input  logic [1:0]          in_op,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [(1<<n)-1:0]   out_bus,
   output logic [(1<<n)-1:0]   mask,
   output logic                any
);

   localparam int unsigned W = 1 << n;

   occ_t           state, state_nxt;
   logic [n-1:0]   head_idx, skid_idx, upd_idx;
   op_t            skid_op, upd_op;
   logic           accept, pop;
   logic           load_in, load_skid, skid_load;
   logic [W-1:0]   head_hot, upd_hot, mask_nxt;

   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Occupancy FSM: decides which storage register loads this cycle.
   always_comb begin
      state_nxt = state;
      load_in   = 1'b0;
      load_skid = 1'b0;
      skid_load = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               load_in   = 1'b1;
            end
         end
         ONE: begin
            case ({accept, pop})
               2'b10: begin
                  state_nxt = TWO;
                  skid_load = 1'b1;
               end
               2'b01: state_nxt = EMPTY;
               2'b11: load_in = 1'b1;
               default: state_nxt = ONE;
            endcase
         end
         TWO: begin
            if (pop) begin
               state_nxt = ONE;
               load_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // The entry being written into the head is the one whose mask op applies.
   assign upd_idx = load_skid ? skid_idx : in_idx;
   assign upd_op  = load_skid ? skid_op  : op_t'(in_op);

   onehot_dec #(.n(n)) u_upd_dec  (.idx(upd_idx),  .onehot(upd_hot));
   onehot_dec #(.n(n)) u_head_dec (.idx(head_idx), .onehot(head_hot));

   always_comb begin
      mask_nxt = mask;
      if (load_in || load_skid) begin
         case (upd_op)
            OP_SET:    mask_nxt = mask | upd_hot;
            OP_CLEAR:  mask_nxt = mask & ~upd_hot;
            OP_TOGGLE: mask_nxt = mask ^ upd_hot;
            default:   mask_nxt = mask;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_idx <= '0;
         skid_idx <= '0;
         skid_op  <= OP_PULSE;
         mask     <= '0;
         any      <= 1'b0;
      end else begin
         if (load_in)        head_idx <= in_idx;
         else if (load_skid) head_idx <= skid_idx;
         if (skid_load) begin
            skid_idx <= in_idx;
            skid_op  <= op_t'(in_op);
         end
         mask <= mask_nxt;
         any  <= |mask_nxt;
      end
   end

   assign out_bus = (state == EMPTY) ? W'(0) : head_hot;

endmodule

// File: doc/dekoder.md
# dekoder

Registered, flow-controlled binary-to-one-hot decoder with a sticky bit mask. It is the inverse partner of the priority encoder block: an n-bit index stream enters through a valid/ready handshake and leaves as a 2**n-bit one-hot bus. Each index can also set, clear or toggle one bit of an internal mask. A 2-entry skid stage keeps full throughput under downstream back-pressure.

## Interface
Parameters:
- n, 8, index width; bus and mask width is 2**n

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  block can accept a command this cycle
- in_idx  in  n  bit index to decode
- in_op  in  2  00 PULSE, 01 SET, 10 CLEAR, 11 TOGGLE
- out_valid  out  1  out_bus holds a decoded result
- out_ready  in  1  downstream consumes the result
- out_bus  out  2**n  one-hot of the index at the head of the output stage
- mask  out  2**n  sticky mask register
- any  out  1  |mask, registered together with mask

## Operation
- Accept: the block takes a command on a cycle with in_valid && in_ready.
- Pop: the head entry leaves on a cycle with out_valid && out_ready.
- Storage:
  - Head register (drives out_bus) plus one skid register.
  - Each entry stores idx and op. out_bus = 1 << head_idx, decoded combinationally from the head register.
- State machine on occupancy:
  - EMPTY
    - accept -> ONE (head loads)
    - otherwise stay
  - ONE
    - accept without pop -> TWO (skid loads)
    - pop without accept -> EMPTY
    - accept with pop -> ONE (head reloads directly from input)
    - otherwise stay
  - TWO
    - pop -> ONE (skid moves to head)
    - otherwise stay
    - No accept is possible in TWO.
- in_ready = (state != TWO). It is a registered state decode, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Mask update: applied on the clock edge where an entry is written into the head register, either from the input or from the skid.
  - SET: mask[idx] <= 1
  - CLEAR: mask[idx] <= 0
  - TOGGLE: mask[idx] <= ~mask[idx]
  - PULSE: mask unchanged
- Consequence of the update rule: mask reflects every command up to and including the one visible on out_bus.
- any is registered. It equals |mask of the same cycle, never lagging.
- Width rule: in_idx is always in range (0..2**n-1), so no out-of-range handling is needed.

## Timing
- Reset (asynchronous, immediate):
  - state EMPTY, out_valid 0, in_ready 1
  - out_bus 0 (forced to 0 while EMPTY)
  - mask 0, any 0, head/skid contents 0
- Reset mid-operation drops both stored entries. No partial mask update survives.
- Latency: a command accepted at edge k appears on out_bus/out_valid, with its mask effect, after edge k. That is 1 cycle.
- Throughput: with out_ready held 1, one command per cycle is sustained indefinitely.
- Back-pressure:
  - out_ready low with state ONE: one more command is absorbed.
  - in_ready drops the cycle after reaching TWO.
- out_bus and out_valid hold stable while out_valid && !out_ready.
- Simultaneous accept and pop in ONE: the new entry replaces the head on the same edge, and its mask op is applied.
- Two consecutive ops on the same idx (e.g. SET then TOGGLE) are applied in order, one per head load.

## Structure
- Shared package dekoder_pkg holds:
  - op encodings OP_PULSE/OP_SET/OP_CLEAR/OP_TOGGLE
  - occupancy state type (EMPTY/ONE/TWO)
  - default N = 8
- Sub-module onehot_dec (parameter n): purely combinational idx -> 2**n one-hot. It is used for out_bus and for the mask bit-select.

## Test plan
- Reset/idle, n=4:
  - assert rst mid-stream -> out_valid 0, in_ready 1, out_bus 0, mask 0, any 0 immediately, without waiting for clk.
- Streaming, n=4, out_ready=1:
  - PULSE idx 0..15 back-to-back -> out_bus = 0x0001, 0x0002 .. 0x8000 on consecutive cycles, 1 cycle after each accept.
  - mask stays 0.
- Mask ops, n=4:
  - SET 3, SET 9, TOGGLE 3, CLEAR 9 -> mask 0x0008, 0x0208, 0x0200, 0x0000; any 1,1,1,0.
- Back-pressure, n=4, out_ready=0:
  - send idx 5 then idx 6 -> in_ready 0 after the second accept; out_bus holds 0x0020.
  - raise out_ready -> 0x0020 then 0x0040; in_ready returns to 1.
- Exhaustive, n=3:
  - random valid/ready toggling over all idx/op combinations.
  - Scoreboard checks order, no loss/duplication, out_bus one-hot, and mask equal to the reference model at every head load.
